uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter that sits directly downstream of the supervised_synapse316 MCU's output registers: it takes the byte on the MCU's `parallel_in` register field and a level-type `load_data` register bit, queues bytes in a small FIFO, and serializes them onto `tx_line`. It replaces the single-byte transmitter model. `tx_busy` feeds back into an MCU `data_in` port so firmware can poll for FIFO space.

---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: edge-triggered enqueue into a circular FIFO, serialized LSB first.
// Optional even parity bit between data and stop when UART_TX_FIFO_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     sysclk,
  input  logic                     sysreset_n,
  input  logic [7:0]               parallel_in,
  input  logic                     load_data,
  output logic                     tx_line,
  output logic                     tx_busy,
  output logic                     tx_idle,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]              BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT  = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_FIFO_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                     state_reg, state_next;
  logic [BW-1:0]              baud_reg, baud_next;
  logic [2:0]                 bit_idx_reg, bit_idx_next;
  logic [7:0]                 shift_reg, shift_next;
  logic                       tx_line_reg, tx_line_next;
  logic                       load_prev_reg;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   count_reg;
  logic                       overflow_reg;
  logic [7:0]                 mem [0:DEPTH-1];
`ifdef UART_TX_FIFO_PARITY_EN
  logic                       parity_reg, parity_next;
`endif

  logic wr, pop, accept, fifo_full, baud_done;

  assign wr        = load_data & ~load_prev_reg;
  assign fifo_full = (count_reg == FULL_COUNT);
  assign accept    = wr & (~fifo_full | pop);
  assign baud_done = (baud_reg == '0);

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_line_next = tx_line_reg;
    pop          = 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_line_next = 1'b1;
        if (count_reg != '0) pop = 1'b1;
      end
      START: begin
        if (baud_done) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          baud_next    = BAUD_RELOAD;
          tx_line_next = shift_reg[0];
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = BAUD_RELOAD;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_FIFO_PARITY_EN
            state_next   = PARITY;
            tx_line_next = parity_reg;
`else
            state_next   = STOP;
            tx_line_next = 1'b1;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_line_next = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
`ifdef UART_TX_FIFO_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_next   = STOP;
          baud_next    = BAUD_RELOAD;
          tx_line_next = 1'b1;
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          if (count_reg != '0) begin
            pop = 1'b1;
          end else begin
            state_next   = IDLE;
            tx_line_next = 1'b1;
          end
        end else begin
          baud_next = baud_reg - BW'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        tx_line_next = 1'b1;
      end
    endcase
    // A pop from IDLE or at stop expiry starts the next frame with no gap.
    if (pop) begin
      shift_next   = mem[rd_ptr_reg];
      baud_next    = BAUD_RELOAD;
      state_next   = START;
      tx_line_next = 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
      parity_next  = ^mem[rd_ptr_reg];
`endif
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_reg     <= IDLE;
      baud_reg      <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      tx_line_reg   <= 1'b1;
      load_prev_reg <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
`ifdef UART_TX_FIFO_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      baud_reg      <= baud_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      tx_line_reg   <= tx_line_next;
      load_prev_reg <= load_data;
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (accept && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !accept) count_reg <= count_reg - 1'b1;
      if (wr && !accept) overflow_reg <= 1'b1;
`ifdef UART_TX_FIFO_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  // Storage carries no reset so it can map onto RAM primitives.
  always_ff @(posedge sysclk) begin
    if (accept) mem[wr_ptr_reg] <= parallel_in;
  end

  assign tx_line    = tx_line_reg;
  assign tx_busy    = fifo_full;
  assign tx_idle    = (state_reg == IDLE) && (count_reg == '0);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue/frame-position reference model compared every cycle,
// plus directed literal checks and a simple serial decoder.
module tb_uart_tx_fifo;
  localparam int C = 4;
  localparam int L = 2;
  localparam int D = 1 << L;
`ifdef UART_TX_FIFO_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic         sysclk = 1'b0;
  logic         sysreset_n = 1'b1;
  logic [7:0]   parallel_in = 8'h00;
  logic         load_data = 1'b0;
  logic         tx_line, tx_busy, tx_idle, overflow;
  logic [L:0]   fifo_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(L)) dut (
    .sysclk(sysclk), .sysreset_n(sysreset_n), .parallel_in(parallel_in), .load_data(load_data),
    .tx_line(tx_line), .tx_busy(tx_busy), .tx_idle(tx_idle), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: byte queue plus position (in cycles) inside the current frame.
  logic [7:0] m_q[$];
  int         m_pos = -1;
  logic [7:0] m_cur = 8'h00;
  logic       m_prev = 1'b0;
  logic       m_ovf = 1'b0;

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (NB == 11 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  always @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      m_q.delete();
      m_pos  = -1;
      m_prev = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      logic m_wr, m_pop;
      m_wr   = load_data && !m_prev;
      m_prev = load_data;
      m_pop  = (m_q.size() > 0) && (m_pos < 0 || m_pos == NB*C-1);
      if (m_pop) begin
        m_cur = m_q.pop_front();
        m_pos = 0;
      end else if (m_pos == NB*C-1) m_pos = -1;
      else if (m_pos >= 0) m_pos++;
      if (m_wr) begin
        if (m_q.size() < D) m_q.push_back(parallel_in);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge sysclk) begin
    if (check_en) begin
      logic [L+4:0] act, exp;
      logic         e_line;
      e_line = (m_pos < 0) ? 1'b1 : frame_bit(m_cur, m_pos / C);
      act = {tx_line, tx_busy, tx_idle, overflow, fifo_count};
      exp = {e_line, (m_q.size() == D), (m_pos < 0 && m_q.size() == 0), m_ovf, (L+1)'(m_q.size())};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t {line,busy,idle,ovf,count} actual=%b expected=%b", $time, act, exp);
      end
    end
  end

  // Serial decoder: samples each bit in its middle.
  logic [7:0] rx_q[$];
  longint     rx_t[$];
  always begin
    @(negedge sysclk);
    if (check_en && sysreset_n && tx_line === 1'b0) begin
      logic [7:0] d;
      longint     t0;
      t0 = $time;
      repeat (C/2) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge sysclk);
        d[i] = tx_line;
      end
`ifdef UART_TX_FIFO_PARITY_EN
      repeat (C) @(negedge sysclk);
`endif
      repeat (C) @(negedge sysclk);
      rx_q.push_back(d);
      rx_t.push_back(t0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic enq(input logic [7:0] b);
    @(negedge sysclk);
    parallel_in = b;
    load_data   = 1'b1;
    @(negedge sysclk);
    load_data   = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] pat55;
    logic [7:0] exp_ab[2];
    pat55 = 10'b1010101010;
    exp_ab[0] = 8'hA3;
    exp_ab[1] = 8'h0F;

    #2 sysreset_n = 1'b0;
    #1 check_en = 1'b1;
    chk("reset_state", {tx_line, tx_busy, tx_idle, overflow, fifo_count}, 32'b1010000);
    repeat (2) @(negedge sysclk);
    sysreset_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // Single byte 0x55
    @(negedge sysclk);
    parallel_in = 8'h55;
    load_data   = 1'b1;
    @(posedge sysclk);
    #1;
    chk("enq_count", fifo_count, 1);
    chk("line_before_start", tx_line, 1);
    @(negedge sysclk);
    load_data = 1'b0;
    for (int m = 0; m <= 40; m++) begin
      @(negedge sysclk);
      if (m == 0) chk("start_fall", tx_line, 0);
      if (m < 40 && (m % C) == 2) chk("bit55", tx_line, pat55[m / C]);
      if (m == 39) chk("idle_in_stop", tx_idle, 0);
      if (m == 40) chk("idle_after_frame", tx_idle, 1);
    end
    repeat (4) @(negedge sysclk);
    chk("rx55_size", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rx55_val", rx_q[0], 8'h55);
    rx_q.delete();
    rx_t.delete();

    // Back-to-back frames
    enq(8'hA3);
    enq(8'h0F);
    repeat (100) @(negedge sysclk);
    chk("b2b_size", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      for (int i = 0; i < 2; i++) chk("b2b_val", rx_q[i], exp_ab[i]);
      chk("b2b_gap", 32'(rx_t[1] - rx_t[0]), 10 * NB * C);
    end
    rx_q.delete();
    rx_t.delete();

    // Fill and overflow
    for (int b = 1; b <= 5; b++) enq(8'(b));
    chk("full_busy", tx_busy, 1);
    chk("full_count", fifo_count, 4);
    chk("no_ovf_yet", overflow, 0);
    enq(8'h06);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", fifo_count, 4);
    repeat (5 * NB * C + 30) @(negedge sysclk);
    chk("ovf_rx_size", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("ovf_order", rx_q[i], i + 1);
    rx_q.delete();
    rx_t.delete();

    // Level hold
    @(negedge sysclk);
    parallel_in = 8'h3C;
    load_data   = 1'b1;
    repeat (100) @(negedge sysclk);
    load_data = 1'b0;
    repeat (60) @(negedge sysclk);
    chk("hold_rx_size", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("hold_rx_val", rx_q[0], 8'h3C);
    chk("hold_idle", tx_idle, 1);
    rx_q.delete();
    rx_t.delete();

    // Reset during data bit 3 of 0x96 (bit 3 is 0)
    enq(8'h96);
    enq(8'h11);
    repeat (16) @(negedge sysclk);
    chk("pre_rst_bit3", tx_line, 0);
    chk("pre_rst_count", fifo_count, 1);
    chk("pre_rst_ovf", overflow, 1);
    #2 sysreset_n = 1'b0;
    #1;
    chk("rst_line", tx_line, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    repeat (2) @(negedge sysclk);
    sysreset_n = 1'b1;
    repeat (60) @(negedge sysclk);
    rx_q.delete();
    rx_t.delete();
    repeat (100) @(negedge sysclk);
    chk("post_rst_silent", rx_q.size(), 0);
    chk("post_rst_idle", tx_idle, 1);

    // Randomized traffic: a fast phase that overflows, then a slow phase with one reset.
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        @(negedge sysclk);
        if ($urandom_range(0, 99) < ((phase == 0) ? 50 : 6)) load_data = ~load_data;
        parallel_in = 8'($urandom);
        if (phase == 1 && i == 700) #2 sysreset_n = 1'b0;
        if (phase == 1 && i == 703) sysreset_n = 1'b1;
      end
    end
    load_data = 1'b0;
    repeat ((D + 2) * NB * C) @(negedge sysclk);
    chk("final_idle", tx_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
